// File: rtl/img_rsz_blk_sched.sv
// img_rsz_blk_sched: dispatches resize blocks to the shared compute engine and
// drains finished blocks in raster order onto the resized-pixel stream.
//
// Ports:
//   Clk, Reset          clock, synchronous active-high reset
//   BlkIsEnough         per-block "all source pixels collected" bitmap (y*RSZ_W+x)
//   CompEngRdy          compute engine idle and ready for a new block
//   CompBlkEn           one-cycle dispatch strobe
//   CompBlkXMsk/YMsk    one-hot coordinates of the dispatched block (0 when idle)
//   CeCompVld           compute engine finished the in-flight block
//   BlkIsExec           per-block "resized result available" bitmap
//   FlushRszPxlData     buffer read data for the current flush masks
//   FlushBlkXMsk/YMsk   one-hot coordinates of the flush pointer
//   FlushVld            combinational strobe clearing the pointed exec flag
//   RszPxlData/Vld/Rdy  resized-pixel valid/ready output stream
//   RszPxlLast          beat carries the last block of the frame
//   FrameDone           one-cycle pulse after the last beat is accepted
//   SchedBusy           dispatch sequencer is not idle
module img_rsz_blk_sched #(
  parameter int unsigned RSZ_W      = 4,
  parameter int unsigned RSZ_H      = 4,
  parameter int unsigned PXL_DATA_W = 24
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic [RSZ_W*RSZ_H-1:0]   BlkIsEnough,
  input  logic                     CompEngRdy,
  output logic                     CompBlkEn,
  output logic [RSZ_W-1:0]         CompBlkXMsk,
  output logic [RSZ_H-1:0]         CompBlkYMsk,
  input  logic                     CeCompVld,
  input  logic [RSZ_W*RSZ_H-1:0]   BlkIsExec,
  input  logic [PXL_DATA_W-1:0]    FlushRszPxlData,
  output logic [RSZ_W-1:0]         FlushBlkXMsk,
  output logic [RSZ_H-1:0]         FlushBlkYMsk,
  output logic                     FlushVld,
  output logic [PXL_DATA_W-1:0]    RszPxlData,
  output logic                     RszPxlVld,
  input  logic                     RszPxlRdy,
  output logic                     RszPxlLast,
  output logic                     FrameDone,
  output logic                     SchedBusy
);

  localparam int unsigned BLK_N = RSZ_W * RSZ_H;
  localparam int unsigned IDX_W = $clog2(BLK_N);
  localparam int unsigned FX_W  = $clog2(RSZ_W);
  localparam int unsigned FY_W  = $clog2(RSZ_H);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } schedState_t;

  // ---------------------------------------------------------------------------
  // Dispatch side
  // ---------------------------------------------------------------------------
  schedState_t        state, stateNxt;
  logic [IDX_W-1:0]   rrPtr, rrPtrNxt;
  logic [IDX_W-1:0]   gntIdx, gntIdxNxt;
  logic [RSZ_W-1:0]   compXMskNxt;
  logic [RSZ_H-1:0]   compYMskNxt;
  logic               compBlkEnNxt;
  logic               schedBusyNxt;

  logic               pickVld;
  logic [IDX_W-1:0]   pickIdx;
  logic [RSZ_W-1:0]   pickXMsk;
  logic [RSZ_H-1:0]   pickYMsk;
  int unsigned        cand;

  // Round-robin search: first set Enough bit at or after rrPtr, with wrap.
  always_comb begin
    pickVld  = 1'b0;
    pickIdx  = '0;
    pickXMsk = '0;
    pickYMsk = '0;
    cand     = 0;
    for (int unsigned i = 0; i < BLK_N; i++) begin
      cand = 32'(rrPtr) + i;
      if (cand >= BLK_N) cand = cand - BLK_N;
      if (!pickVld && BlkIsEnough[IDX_W'(cand)]) begin
        pickVld  = 1'b1;
        pickIdx  = IDX_W'(cand);
        pickXMsk = RSZ_W'(1) << (cand % RSZ_W);
        pickYMsk = RSZ_H'(1) << (cand / RSZ_W);
      end
    end
  end

  // Dispatch next-state and registered outputs.
  always_comb begin
    stateNxt     = state;
    rrPtrNxt     = rrPtr;
    gntIdxNxt    = gntIdx;
    compXMskNxt  = CompBlkXMsk;
    compYMskNxt  = CompBlkYMsk;
    compBlkEnNxt = 1'b0;
    unique case (state)
      IDLE: begin
        if (CompEngRdy && pickVld) begin
          stateNxt     = ISSUE;
          gntIdxNxt    = pickIdx;
          compXMskNxt  = pickXMsk;
          compYMskNxt  = pickYMsk;
          compBlkEnNxt = 1'b1;   // strobe lands in the ISSUE cycle
        end
      end
      ISSUE: begin
        stateNxt = WAIT;
        rrPtrNxt = (32'(gntIdx) == BLK_N - 1) ? '0 : gntIdx + IDX_W'(1);
      end
      WAIT: begin
        // Enough bits are ignored here; the in-flight bit clears a cycle late.
        if (CeCompVld) begin
          stateNxt    = IDLE;
          compXMskNxt = '0;
          compYMskNxt = '0;
        end
      end
      default: begin
        stateNxt    = IDLE;
        compXMskNxt = '0;
        compYMskNxt = '0;
      end
    endcase
    schedBusyNxt = (stateNxt != IDLE);
  end

  // Dispatch state register.
  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= stateNxt;
  end

  // Dispatch data registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      rrPtr       <= '0;
      gntIdx      <= '0;
      CompBlkEn   <= 1'b0;
      CompBlkXMsk <= '0;
      CompBlkYMsk <= '0;
      SchedBusy   <= 1'b0;
    end else begin
      rrPtr       <= rrPtrNxt;
      gntIdx      <= gntIdxNxt;
      CompBlkEn   <= compBlkEnNxt;
      CompBlkXMsk <= compXMskNxt;
      CompBlkYMsk <= compYMskNxt;
      SchedBusy   <= schedBusyNxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Flush side
  // ---------------------------------------------------------------------------
  logic [FX_W-1:0]        fx, fxNxt;
  logic [FY_W-1:0]        fy, fyNxt;
  logic [IDX_W-1:0]       flushIdx;
  logic                   fire;
  logic                   lastBlk;
  logic [PXL_DATA_W-1:0]  pxlDataNxt;
  logic                   pxlVldNxt;
  logic                   pxlLastNxt;
  logic                   frameDoneNxt;

  assign flushIdx     = IDX_W'(32'(fy) * RSZ_W + 32'(fx));
  assign lastBlk      = (32'(fx) == RSZ_W - 1) && (32'(fy) == RSZ_H - 1);
  assign FlushBlkXMsk = RSZ_W'(1) << fx;
  assign FlushBlkYMsk = RSZ_H'(1) << fy;

  // Fire when the pointed block is ready and the output slot is free or draining.
  assign fire     = BlkIsExec[flushIdx] & (~RszPxlVld | RszPxlRdy);
  assign FlushVld = fire;

  // Pointer advance and output beat next values.
  always_comb begin
    fxNxt      = fx;
    fyNxt      = fy;
    pxlDataNxt = RszPxlData;
    pxlVldNxt  = RszPxlVld;
    pxlLastNxt = RszPxlLast;
    if (fire) begin
      pxlDataNxt = FlushRszPxlData;
      pxlVldNxt  = 1'b1;
      pxlLastNxt = lastBlk;
      // Moving on the fire cycle keeps the stale exec bit from being resampled.
      if (32'(fx) == RSZ_W - 1) begin
        fxNxt = '0;
        fyNxt = (32'(fy) == RSZ_H - 1) ? '0 : fy + FY_W'(1);
      end else begin
        fxNxt = fx + FX_W'(1);
      end
    end else if (RszPxlVld && RszPxlRdy) begin
      pxlVldNxt  = 1'b0;
      pxlLastNxt = 1'b0;
    end
    frameDoneNxt = RszPxlVld & RszPxlRdy & RszPxlLast;
  end

  // Flush pointer and output stream registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      fx         <= '0;
      fy         <= '0;
      RszPxlData <= '0;
      RszPxlVld  <= 1'b0;
      RszPxlLast <= 1'b0;
      FrameDone  <= 1'b0;
    end else begin
      fx         <= fxNxt;
      fy         <= fyNxt;
      RszPxlData <= pxlDataNxt;
      RszPxlVld  <= pxlVldNxt;
      RszPxlLast <= pxlLastNxt;
      FrameDone  <= frameDoneNxt;
    end
  end

endmodule
